// File: rtl/queue_wr_arbiter.sv
// ---------------------------------------------------------------------------
// queue_wr_arbiter
//
// Round-robin write arbiter that lets NUM_REQ producers share the write side
// of a single FIFO queue. One producer is granted at a time for a burst of at
// most MAX_BURST writes. A write is never issued while the queue reports
// full, so the queue never drops a word.
//
// Each burst starts with one IDLE arbitration cycle (no write). In BURST the
// grant is combinational: the owner's word is written on any cycle where the
// owner still requests and the queue has room.
//
// Optional feature (macro QARB_STALL_STATS_EN):
//   Adds output stall_cnt[15:0]. It counts the cycles where the burst owner
//   requests but the queue is full. It saturates at 16'hFFFF.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (0 = in reset)
//   req       in   [NUM_REQ]        producer i has a word on its lane
//   req_data  in   [NUM_REQ*WIDTH]  producer i word at [i*WIDTH +: WIDTH]
//   gnt       out  [NUM_REQ]        one-hot; producer i's word written this edge
//   q_full    in   queue full flag
//   q_wr      out  queue write strobe
//   q_data    out  [WIDTH]          queue write data (0 when not writing)
//   busy      out  1 while a burst is in progress
//   owner     out  [ID_W]           index of the current / last burst owner
//   stall_cnt out  [16]             (QARB_STALL_STATS_EN only) stall cycles
// ---------------------------------------------------------------------------
module queue_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       gnt,
   input  logic                     q_full,
   output logic                     q_wr,
   output logic [WIDTH-1:0]         q_data,
   output logic                     busy,
   output logic [ID_W-1:0]          owner
`ifdef QARB_STALL_STATS_EN
   ,
   output logic [15:0]              stall_cnt
`endif
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] owner_q, owner_d;
   logic [3:0]      burst_cnt_q, burst_cnt_d;

   // Unpack the producer data lanes into an array for simple indexing.
   logic [WIDTH-1:0] lane [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign lane[gi] = req_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Round-robin search. The first requester found starting at rr_ptr wins.
   logic            pick_found;
   logic [ID_W-1:0] pick_idx;

   always_comb begin
      int cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'(cand);
         end
      end
   end

   logic            owner_req;
   logic [ID_W-1:0] owner_inc;

   assign owner_req = req[owner_q];
   // Explicit wrap, so that rr_ptr never reaches NUM_REQ when NUM_REQ < 2**ID_W.
   assign owner_inc = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + ID_W'(1);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gnt         = '0;
      q_wr        = 1'b0;
      q_data      = '0;
      case (state_q)
         IDLE: begin
            if (pick_found && !q_full) begin
               owner_d     = pick_idx;
               burst_cnt_d = 4'd0;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (!owner_req) begin
               // The owner gave up. Release the bus without a write.
               state_d  = IDLE;
               rr_ptr_d = owner_inc;
            end else if (!q_full) begin
               gnt[owner_q] = 1'b1;
               q_wr         = 1'b1;
               q_data       = lane[owner_q];
               burst_cnt_d  = burst_cnt_q + 4'd1;
               if (burst_cnt_q == 4'(MAX_BURST - 1)) begin
                  state_d  = IDLE;
                  rr_ptr_d = owner_inc;
               end
            end
            // The owner requests but the queue is full: stall. Hold all
            // state, and do not let any other producer in.
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign busy  = (state_q == BURST);
   assign owner = owner_q;

`ifdef QARB_STALL_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == BURST && owner_req && q_full && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_queue_wr_arbiter
//
// Directed testbench for queue_wr_arbiter (NUM_REQ=4, MAX_BURST=4, WIDTH=8).
// A behavioural 16-entry FIFO stands in for the queue. Inputs change 1 ns
// after the rising edge. Outputs are sampled 1 ns after that.
// ---------------------------------------------------------------------------
module tb_queue_wr_arbiter;
   localparam int WIDTH     = 8;
   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 4;
   localparam int ID_W      = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt;
   logic        q_full;
   logic        q_wr;
   logic [7:0]  q_data;
   logic        busy;
   logic [1:0]  owner;
`ifdef QARB_STALL_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   queue_wr_arbiter #(
      .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .q_full   (q_full),
      .q_wr     (q_wr),
      .q_data   (q_data),
      .busy     (busy),
      .owner    (owner)
`ifdef QARB_STALL_STATS_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   // Behavioural LENGTH=16 queue. The bench can prefill, pop and flush it.
   logic [7:0] fifo [$];
   int         q_cnt = 0;
   int         overflow = 0;
   logic       pop_en = 1'b0, fill_en = 1'b0, flush = 1'b0;
   logic [7:0] fill_data = '0, last_pop = '0;

   assign q_full = (q_cnt == 16);

   always @(posedge clk) begin
      logic [7:0] tmp;
      if (flush) begin
         fifo.delete();
      end else begin
         if (q_wr && q_full) overflow <= overflow + 1;
         if (pop_en && fifo.size() > 0) begin
            tmp = fifo.pop_front();
            last_pop <= tmp;
         end
         if (q_wr) fifo.push_back(q_data);
         if (fill_en) fifo.push_back(fill_data);
      end
      q_cnt <= fifo.size();
      if (q_wr) $display("write: owner=%0d gnt=%b data=%h", owner, gnt, q_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; flush = 1'b1; req = '0; pop_en = 1'b0; fill_en = 1'b0;
      step;
      step;
      #1;
      checks++;
      if ({gnt, q_wr, busy, owner, q_data} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs gnt=%b q_wr=%b busy=%b owner=%0d q_data=%h expected all zero",
                  gnt, q_wr, busy, owner, q_data);
      end
`ifdef QARB_STALL_STATS_EN
      checks++;
      if (stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_stall_cnt got=%0d expected=0", stall_cnt);
      end
`endif
      flush = 1'b0;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0; req = 4'b1111; req_data = 32'hDEADBEEF;
      step;
      #1;
      checks++;
      if (gnt !== 4'b0000 || q_wr !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_write gnt=%b q_wr=%b expected gnt=0000 q_wr=0", gnt, q_wr);
      end
      checks++;
      if (busy !== 1'b0 || owner !== 2'd0 || q_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_state busy=%b owner=%0d q_data=%h expected 0/0/00", busy, owner, q_data);
      end
      do_reset;
      $display("test_reset done");
   endtask

   // Producer 0 alone: 4 writes, 1 bubble, 4 writes, then read back in order.
   task automatic test_single_producer;
      logic wr_exp;
      int   n;
      do_reset;
      req = 4'b0001;
      n = 0;
      for (int c = 0; c < 10; c++) begin
         wr_exp = !(c == 0 || c == 5);
         req_data[7:0] = 8'(8'h10 + n);
         #1;
         checks++;
         if (q_wr !== wr_exp ||
             (wr_exp && (q_data !== 8'(8'h10 + n) || gnt !== 4'b0001 || owner !== 2'd0))) begin
            failures++;
            $display("FAIL single_c%0d q_wr=%b gnt=%b owner=%0d data=%h expected q_wr=%b gnt=0001 owner=0 data=%h",
                     c, q_wr, gnt, owner, q_data, wr_exp, 8'(8'h10 + n));
         end
         if (wr_exp) n++;
         step;
      end
      req = '0;
      pop_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step;
         checks++;
         if (last_pop !== 8'(8'h10 + k)) begin
            failures++;
            $display("FAIL single_readback_%0d got=%h expected=%h", k, last_pop, 8'(8'h10 + k));
         end
      end
      pop_en = 1'b0;
      $display("test_single_producer done");
   endtask

   // All four producers request: bursts rotate 0,1,2,3,0 with one bubble each.
   task automatic test_round_robin;
      logic       wr_exp;
      int         o;
      logic [3:0] gnt_exp;
      logic [7:0] data_exp;
      do_reset;
      pop_en = 1'b1;
      req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req = 4'b1111;
      for (int c = 0; c < 25; c++) begin
         #1;
         wr_exp   = (c % 5) != 0;
         o        = (c / 5) % 4;
         gnt_exp  = wr_exp ? 4'(1 << o) : 4'b0000;
         data_exp = wr_exp ? 8'(8'hA0 + o * 8'h11) : 8'h00;
         checks++;
         if ({q_wr, busy, gnt, q_data} !== {wr_exp, wr_exp, gnt_exp, data_exp} ||
             (wr_exp && owner !== 2'(o))) begin
            failures++;
            $display("FAIL rr_c%0d q_wr=%b busy=%b gnt=%b owner=%0d data=%h expected q_wr=%b busy=%b gnt=%b owner=%0d data=%h",
                     c, q_wr, busy, gnt, owner, q_data, wr_exp, wr_exp, gnt_exp, o, data_exp);
         end
         step;
      end
      req = '0;
      step;
      pop_en = 1'b0;
      $display("test_round_robin done");
   endtask

   // Queue at 15/16: one write, then stall while full; one pop lets the next write in.
   task automatic test_full_stall;
      logic [7:0] exp;
      do_reset;
      fill_en = 1'b1;
      for (int k = 0; k < 15; k++) begin
         fill_data = 8'(k);
         step;
      end
      fill_en = 1'b0;
      req_data = 32'h00A5_0000;
      req = 4'b0100;
      #1;
      checks++;
      if (q_wr !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL full_arb_bubble q_wr=%b busy=%b expected 0/0", q_wr, busy);
      end
      step;
      #1;
      checks++;
      if (gnt !== 4'b0100 || q_data !== 8'hA5) begin
         failures++;
         $display("FAIL full_first_write gnt=%b data=%h expected gnt=0100 data=a5", gnt, q_data);
      end
      step;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0000 || q_wr !== 1'b0 || busy !== 1'b1 || owner !== 2'd2) begin
            failures++;
            $display("FAIL full_stall_c%0d gnt=%b q_wr=%b busy=%b owner=%0d expected 0000/0/1/2",
                     c, gnt, q_wr, busy, owner);
         end
         step;
      end
      pop_en = 1'b1;
      step;
      pop_en = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0100 || q_data !== 8'hA5 || last_pop !== 8'h00) begin
         failures++;
         $display("FAIL full_resume gnt=%b data=%h popped=%h expected gnt=0100 data=a5 popped=00",
                  gnt, q_data, last_pop);
      end
      step;
      req = '0;
      pop_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step;
         exp = (k < 14) ? 8'(k + 1) : 8'hA5;
         checks++;
         if (last_pop !== exp) begin
            failures++;
            $display("FAIL full_readback_%0d got=%h expected=%h", k, last_pop, exp);
         end
      end
      pop_en = 1'b0;
      $display("test_full_stall done");
   endtask

   // Owner 1 drops its request mid-burst. rr_ptr moves to 2, so 3 wins over 0.
   task automatic test_drop_req;
      do_reset;
      pop_en = 1'b1;
      req_data = {8'h33, 8'h22, 8'h11, 8'h01};
      req = 4'b1010;
      step;
      for (int c = 1; c < 3; c++) begin
         #1;
         checks++;
         if (gnt !== 4'b0010 || owner !== 2'd1 || q_data !== 8'h11) begin
            failures++;
            $display("FAIL drop_write_c%0d gnt=%b owner=%0d data=%h expected 0010/1/11", c, gnt, owner, q_data);
         end
         step;
      end
      req = 4'b1001;
      #1;
      checks++;
      if (q_wr !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL drop_release q_wr=%b busy=%b expected 0/1", q_wr, busy);
      end
      step;
      #1;
      checks++;
      if (q_wr !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL drop_idle q_wr=%b busy=%b expected 0/0", q_wr, busy);
      end
      step;
      #1;
      checks++;
      if (gnt !== 4'b1000 || owner !== 2'd3 || q_data !== 8'h33) begin
         failures++;
         $display("FAIL drop_next_owner gnt=%b owner=%0d data=%h expected 1000/3/33", gnt, owner, q_data);
      end
      req = '0;
      step;
      pop_en = 1'b0;
      $display("test_drop_req done");
   endtask

   // Reset mid-burst kills the write at once. Arbitration then restarts from 0.
   task automatic test_reset_mid_burst;
      do_reset;
      req_data = {8'h44, 8'h33, 8'h22, 8'h55};
      req = 4'b0001;
      for (int c = 0; c < 7; c++) step;
      #1;
      checks++;
      if (gnt !== 4'b0001 || q_data !== 8'h55) begin
         failures++;
         $display("FAIL rstmid_pre_write gnt=%b data=%h expected 0001/55", gnt, q_data);
      end
      step;
      reset = 1'b0;
      req = 4'b0011;
      #1;
      checks++;
      if ({gnt, q_wr, busy, owner, q_data} !== 16'h0) begin
         failures++;
         $display("FAIL rstmid_immediate gnt=%b q_wr=%b busy=%b owner=%0d data=%h expected all zero",
                  gnt, q_wr, busy, owner, q_data);
      end
      step;
      reset = 1'b1;
      #1;
      checks++;
      if (q_wr !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_release q_wr=%b busy=%b expected 0/0", q_wr, busy);
      end
      step;
      #1;
      checks++;
      if (gnt !== 4'b0001 || owner !== 2'd0 || q_data !== 8'h55) begin
         failures++;
         $display("FAIL rstmid_restart gnt=%b owner=%0d data=%h expected 0001/0/55", gnt, owner, q_data);
      end
      req = '0;
      step;
      $display("test_reset_mid_burst done");
   endtask

`ifdef QARB_STALL_STATS_EN
   task automatic test_stall_stats;
      do_reset;
      fill_en = 1'b1;
      for (int k = 0; k < 15; k++) begin
         fill_data = 8'(k);
         step;
      end
      fill_en = 1'b0;
      req_data = 32'h0000_0077;
      req = 4'b0001;
      step;
      step;
      #1;
      checks++;
      if (stall_cnt !== 16'd0) begin
         failures++;
         $display("FAIL stats_start got=%0d expected=0", stall_cnt);
      end
      for (int c = 0; c < 5; c++) step;
      #1;
      checks++;
      if (stall_cnt !== 16'd5 || gnt !== 4'b0000) begin
         failures++;
         $display("FAIL stats_five got=%0d gnt=%b expected=5 gnt=0000", stall_cnt, gnt);
      end
      req = '0;
      step;
      step;
      #1;
      checks++;
      if (stall_cnt !== 16'd5) begin
         failures++;
         $display("FAIL stats_hold got=%0d expected=5", stall_cnt);
      end
      $display("test_stall_stats done");
   endtask
`endif

   initial begin
      test_reset;
      test_single_producer;
      test_round_robin;
      test_full_stall;
      test_drop_req;
      test_reset_mid_burst;
`ifdef QARB_STALL_STATS_EN
      test_stall_stats;
`endif
      checks++;
      if (overflow !== 0) begin
         failures++;
         $display("FAIL queue_overflow writes_while_full=%0d expected=0", overflow);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
